// File: rtl/commit_reorder_stage.sv
// commit_reorder_stage
//   Reorder window between the execute pipeline and writeback. ALU results tagged with
//   commit_id arrive in any order into a depth-entry window (slot = commit_id mod depth).
//   They leave strictly in commit_id order through a valid/ready output register. The
//   result can optionally be narrowed with an arithmetic shift and saturation at write time.
//
// Ports
//   clk, reset (sync, active-low), enable (global advance), flush (sync clear)
//   in_valid/in_ready, block_in, result_in, dest_in, commit_id_in, commit_flag_in : input entry
//   out_valid/out_ready, block_out, result_out, dest_out, commit_id_out, commit_flag_out :
//     committed entry
//   occupancy    : filled window slots, output register excluded
//   window_stall : presented id is outside the window or its slot is already taken
module commit_reorder_stage #(
   parameter int unsigned data_width = 16,
   parameter int unsigned n_blocks   = 256,
   parameter int unsigned id_width   = 9,
   parameter int unsigned depth      = 8,
   parameter int unsigned saturate   = 1,
   parameter int unsigned sat_shift  = 15
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          enable,
   input  logic                          flush,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [$clog2(n_blocks)-1:0]   block_in,
   input  logic [2*data_width-1:0]       result_in,
   input  logic [3:0]                    dest_in,
   input  logic [id_width-1:0]           commit_id_in,
   input  logic                          commit_flag_in,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [$clog2(n_blocks)-1:0]   block_out,
   output logic [2*data_width-1:0]       result_out,
   output logic [3:0]                    dest_out,
   output logic [id_width-1:0]           commit_id_out,
   output logic                          commit_flag_out,
   output logic [$clog2(depth):0]        occupancy,
   output logic                          window_stall
);

   localparam int unsigned bw = $clog2(n_blocks);
   localparam int unsigned rw = 2 * data_width;
   localparam int unsigned iw = $clog2(depth);
   localparam int unsigned ow = iw + 1;

   localparam logic [id_width-1:0] depth_id = id_width'(depth);
   // Largest / smallest value representable in data_width signed, at full result width.
   localparam logic signed [rw-1:0] sat_max =
      {{(data_width + 1){1'b0}}, {(data_width - 1){1'b1}}};
   localparam logic signed [rw-1:0] sat_min = ~sat_max;

   typedef struct packed {
      logic [bw-1:0]       block;
      logic [rw-1:0]       result;
      logic [3:0]          dest;
      logic [id_width-1:0] id;
      logic                flag;
   } entry_t;

   entry_t              slot_q [depth];
   entry_t              slot_d [depth];
   logic [depth-1:0]    slot_valid_q, slot_valid_d;
   logic [id_width-1:0] head_id_q, head_id_d;
   entry_t              out_q, out_d;
   logic                out_valid_q, out_valid_d;
   logic [ow-1:0]       occ_q, occ_d;

   logic [iw-1:0]       in_idx, head_idx;
   logic [id_width-1:0] win_off;
   logic                in_window;
   logic                accept, commit;
   logic signed [rw-1:0] shifted;
   logic [rw-1:0]       sat_result;
   entry_t              in_entry;

   // Window test and handshake
   always_comb begin
      in_idx       = commit_id_in[iw-1:0];
      head_idx     = head_id_q[iw-1:0];
      win_off      = commit_id_in - head_id_q;   // modulo 2^id_width
      in_window    = (win_off < depth_id);
      in_ready     = enable && !flush && in_window && !slot_valid_q[in_idx];
      window_stall = in_valid && enable && !flush && !in_ready;
      accept       = in_valid && in_ready;
      // Accept and commit never target the same slot: commit needs the head slot full,
      // accept needs its slot empty.
      commit       = enable && !flush && slot_valid_q[head_idx] && (!out_valid_q || out_ready);
   end

   // Optional narrowing, applied on the way into the window
   always_comb begin
      shifted    = $signed(result_in) >>> sat_shift;
      sat_result = result_in;
      if (saturate != 0) begin
         if (shifted > sat_max) begin
            sat_result = sat_max;
         end else if (shifted < sat_min) begin
            sat_result = sat_min;
         end else begin
            sat_result = shifted;
         end
      end
      in_entry.block  = block_in;
      in_entry.result = sat_result;
      in_entry.dest   = dest_in;
      in_entry.id     = commit_id_in;
      in_entry.flag   = commit_flag_in;
   end

   // Next state
   always_comb begin
      slot_d       = slot_q;
      slot_valid_d = slot_valid_q;
      head_id_d    = head_id_q;
      out_d        = out_q;
      out_valid_d  = out_valid_q;
      occ_d        = occ_q;
      if (flush) begin
         slot_valid_d = '0;
         head_id_d    = '0;
         out_d        = '0;
         out_valid_d  = 1'b0;
         occ_d        = '0;
      end else if (enable) begin
         if (commit) begin
            out_d                  = slot_q[head_idx];
            out_valid_d            = 1'b1;
            slot_valid_d[head_idx] = 1'b0;
            head_id_d              = head_id_q + 1'b1;
         end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
         end
         if (accept) begin
            slot_d[in_idx]       = in_entry;
            slot_valid_d[in_idx] = 1'b1;
         end
         occ_d = occ_q + ow'(accept) - ow'(commit);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         slot_valid_q <= '0;
         head_id_q    <= '0;
         out_q        <= '0;
         out_valid_q  <= 1'b0;
         occ_q        <= '0;
      end else begin
         slot_valid_q <= slot_valid_d;
         head_id_q    <= head_id_d;
         out_q        <= out_d;
         out_valid_q  <= out_valid_d;
         occ_q        <= occ_d;
      end
   end

   // Slot payloads are qualified by slot_valid_q, so they need no reset.
   always_ff @(posedge clk) begin
      slot_q <= slot_d;
   end

   always_comb begin
      out_valid       = out_valid_q;
      block_out       = out_q.block;
      result_out      = out_q.result;
      dest_out        = out_q.dest;
      commit_id_out   = out_q.id;
      commit_flag_out = out_q.flag;
      occupancy       = occ_q;
   end

endmodule

// File: tb/tb_commit_reorder_stage.sv
module tb_commit_reorder_stage;

   logic        clk = 1'b0;
   logic        reset, enable, flush;
   logic        in_valid, in_ready;
   logic [7:0]  block_in, block_out;
   logic [31:0] result_in, result_out;
   logic [3:0]  dest_in, dest_out;
   logic [8:0]  commit_id_in, commit_id_out;
   logic        commit_flag_in, commit_flag_out;
   logic        out_valid, out_ready;
   logic [3:0]  occupancy;
   logic        window_stall;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   commit_reorder_stage dut (
      .clk             (clk),
      .reset           (reset),
      .enable          (enable),
      .flush           (flush),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .block_in        (block_in),
      .result_in       (result_in),
      .dest_in         (dest_in),
      .commit_id_in    (commit_id_in),
      .commit_flag_in  (commit_flag_in),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .block_out       (block_out),
      .result_out      (result_out),
      .dest_out        (dest_out),
      .commit_id_out   (commit_id_out),
      .commit_flag_out (commit_flag_out),
      .occupancy       (occupancy),
      .window_stall    (window_stall)
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic [8:0] id, input logic [31:0] res);
      in_valid       = 1'b1;
      commit_id_in   = id;
      result_in      = res;
      block_in       = id[7:0];
      dest_in        = id[3:0];
      commit_flag_in = id[0];
      #1;
   endtask

   task automatic send(input string tag, input logic [8:0] id, input logic [31:0] res);
      present(id, res);
      check_val(tag, 64'(in_ready), 64'd1);
      step();
   endtask

   task automatic check_out(input string tag, input logic [8:0] id, input logic [31:0] res);
      check_val({tag, "_valid"}, 64'(out_valid), 64'd1);
      check_val({tag, "_id"}, 64'(commit_id_out), 64'(id));
      check_val({tag, "_res"}, 64'(result_out), 64'(res));
      check_val({tag, "_blk"}, 64'(block_out), 64'(id[7:0]));
      check_val({tag, "_dest"}, 64'(dest_out), 64'(id[3:0]));
      check_val({tag, "_flag"}, 64'(commit_flag_out), 64'(id[0]));
   endtask

   task automatic check_cleared(input string tag);
      check_val({tag, "_valid"}, 64'(out_valid), 64'd0);
      check_val({tag, "_occ"}, 64'(occupancy), 64'd0);
      check_val({tag, "_res"}, 64'(result_out), 64'd0);
      check_val({tag, "_id"}, 64'(commit_id_out), 64'd0);
   endtask

   logic [8:0] wrap_ids [8];

   initial begin
      reset = 1'b0; enable = 1'b1; flush = 1'b0; out_ready = 1'b1;
      in_valid = 1'b0; commit_id_in = '0; result_in = '0; block_in = '0;
      dest_in = '0; commit_flag_in = 1'b0;
      step(); step();
      check_cleared("rst");
      reset = 1'b1;
      #1;
      check_val("rst_rdy_idle", 64'(in_ready), 64'd1);

      // In-order stream: result id<<15 narrows back to id
      for (int i = 0; i < 16; i++) begin
         present(9'(i), 32'(i) << 15);
         check_val("str_rdy", 64'(in_ready), 64'd1);
         check_val("str_ovalid", 64'(out_valid), 64'(i >= 2));
         check_val("str_occ", 64'(occupancy), 64'(i == 0 ? 0 : 1));
         if (i >= 2) check_out("str_out", 9'(i - 2), 32'(i - 2));
         step();
      end
      in_valid = 1'b0;
      check_out("str_t14", 9'd14, 32'd14);
      step();
      check_out("str_t15", 9'd15, 32'd15);
      check_val("str_occ_end", 64'(occupancy), 64'd0);
      step();
      check_val("str_drained", 64'(out_valid), 64'd0);

      // Reorder: head=16, send 19,17,18,16
      send("ro_19", 9'd19, 32'd19 << 15);
      send("ro_17", 9'd17, 32'd17 << 15);
      send("ro_18", 9'd18, 32'd18 << 15);
      check_val("ro_hold", 64'(out_valid), 64'd0);
      send("ro_16", 9'd16, 32'd16 << 15);
      in_valid = 1'b0;
      check_val("ro_occ4", 64'(occupancy), 64'd4);
      check_val("ro_none", 64'(out_valid), 64'd0);
      for (int k = 0; k < 4; k++) begin
         step();
         check_out("ro_out", 9'(16 + k), 32'(16 + k));
         check_val("ro_occ", 64'(occupancy), 64'(3 - k));
      end
      step();
      check_val("ro_drained", 64'(out_valid), 64'd0);

      // Window / duplicate, head=20
      present(9'd28, 32'd0);
      check_val("win_out_rdy", 64'(in_ready), 64'd0);
      check_val("win_out_stall", 64'(window_stall), 64'd1);
      step();
      check_val("win_out_stall2", 64'(window_stall), 64'd1);
      send("dup_first", 9'd22, 32'd22 << 15);
      present(9'd22, 32'd22 << 15);
      check_val("dup_rdy", 64'(in_ready), 64'd0);
      check_val("dup_stall", 64'(window_stall), 64'd1);
      step();
      send("win_24", 9'd24, 32'd24 << 15);
      send("win_20", 9'd20, 32'd20 << 15);
      present(9'd28, 32'd28 << 15);
      check_val("win_pre_commit", 64'(in_ready), 64'd0);
      step();
      check_val("win_post_commit", 64'(in_ready), 64'd1);
      check_out("win_o20", 9'd20, 32'd20);
      step();
      in_valid = 1'b0;
      check_val("win_occ3", 64'(occupancy), 64'd3);

      // Flush with 3 slots filled
      flush = 1'b1;
      present(9'd21, 32'd0);
      check_val("fl_rdy", 64'(in_ready), 64'd0);
      check_val("fl_stall", 64'(window_stall), 64'd0);
      step();
      flush = 1'b0;
      in_valid = 1'b0;
      #1;
      check_cleared("fl");
      present(9'd8, 32'd0);
      check_val("fl_id8", 64'(in_ready), 64'd0);
      present(9'd21, 32'd0);
      check_val("fl_id21", 64'(in_ready), 64'd0);

      // Backpressure: 9 sends, output holds id 0, window full behind it
      out_ready = 1'b0;
      for (int i = 0; i < 9; i++) send("bp_send", 9'(i), 32'(i + 100) << 15);
      check_val("bp_occ8", 64'(occupancy), 64'd8);
      present(9'd9, 32'd0);
      check_val("bp_full_rdy", 64'(in_ready), 64'd0);
      check_val("bp_full_stall", 64'(window_stall), 64'd1);
      for (int c = 0; c < 5; c++) begin
         step();
         check_out("bp_hold", 9'd0, 32'd100);
         check_val("bp_hold_occ", 64'(occupancy), 64'd8);
      end
      // Freeze: out_ready high but enable low
      enable = 1'b0;
      out_ready = 1'b1;
      #1;
      check_val("en0_rdy", 64'(in_ready), 64'd0);
      check_val("en0_stall", 64'(window_stall), 64'd0);
      step(); step();
      check_out("en0_hold", 9'd0, 32'd100);
      check_val("en0_occ", 64'(occupancy), 64'd8);
      enable = 1'b1;
      in_valid = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         step();
         check_out("bp_drain", 9'(k), 32'(k + 100));
         check_val("bp_drain_occ", 64'(occupancy), 64'(8 - k));
      end
      step();
      check_val("bp_drained", 64'(out_valid), 64'd0);

      // Saturation, head=9
      out_ready = 1'b0;
      send("sat_s9", 9'd9, 32'h7FFF_0000);
      send("sat_s10", 9'd10, 32'h8000_0000);
      send("sat_s11", 9'd11, 32'h0000_8000);
      send("sat_s12", 9'd12, 32'hFFFF_0000);
      in_valid = 1'b0;
      check_out("sat_pos", 9'd9, 32'h0000_7FFF);
      out_ready = 1'b1;
      step();
      check_out("sat_neg", 9'd10, 32'hFFFF_8000);
      step();
      check_out("sat_one", 9'd11, 32'h0000_0001);
      step();
      check_out("sat_m2", 9'd12, 32'hFFFF_FFFE);
      step();

      // Advance head to 508
      for (int i = 13; i < 508; i++) begin
         present(9'(i), 32'd0);
         step();
      end
      in_valid = 1'b0;
      step(); step();
      check_val("adv_idle", 64'(out_valid), 64'd0);
      check_val("adv_occ", 64'(occupancy), 64'd0);

      // Wrap: ids 508..3 scrambled
      wrap_ids = '{9'd511, 9'd0, 9'd3, 9'd508, 9'd1, 9'd2, 9'd509, 9'd510};
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) send("wr_send", wrap_ids[i], 32'(wrap_ids[i]) << 15);
      in_valid = 1'b0;
      check_out("wr_508", 9'd508, 32'd508);
      check_val("wr_occ", 64'(occupancy), 64'd7);
      out_ready = 1'b1;
      for (int k = 1; k < 8; k++) begin
         step();
         check_out("wr_out", 9'((508 + k) % 512), 32'((508 + k) % 512));
      end
      step();
      check_val("wr_drained", 64'(out_valid), 64'd0);

      // Reset mid-burst, head=4
      out_ready = 1'b0;
      send("rb_4", 9'd4, 32'd4 << 15);
      send("rb_5", 9'd5, 32'd5 << 15);
      present(9'd6, 32'd6 << 15);
      reset = 1'b0;
      step();
      reset = 1'b1;
      in_valid = 1'b0;
      #1;
      check_cleared("rb");
      out_ready = 1'b1;
      present(9'd8, 32'd0);
      check_val("rb_id8", 64'(in_ready), 64'd0);
      send("rb_0", 9'd0, 32'd7 << 15);
      in_valid = 1'b0;
      step();
      check_out("rb_out0", 9'd0, 32'd7);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
